// File: rtl/pc_sequencer.sv
// Program counter register, next-fetch-address selection and a circular return-address stack
// that predicts JR $ra targets for decode.
module pc_sequencer #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h8000_0180),
  parameter int unsigned       RAS_DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_exception,
  input  logic [31:0]       i_instruction,
  input  logic              i_jump,
  input  logic              i_link,
  input  logic              i_jr,
  input  logic              i_jr_is_return,
  input  logic [ADDR_W-1:0] i_jr_target,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus4,
  output logic [ADDR_W-1:0] o_ras_top,
  output logic              o_ras_empty,
  output logic              o_ras_mispredict,
  output logic              o_ras_underflow
);

  localparam int unsigned      PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_jump_addr;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_top;
  logic [PTR_W-1:0]  w_top_inc;
  logic [PTR_W-1:0]  w_top_dec;
  logic [CNT_W-1:0]  r_count;
  logic              r_underflow;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_unused;

  assign w_unused    = ^i_instruction[31:26];
  assign w_pc_plus4  = r_pc + ADDR_W'(4);
  // Pseudo-direct target keeps the region bits of the delay-slot address.
  assign w_jump_addr = {w_pc_plus4[ADDR_W-1:28], i_instruction[25:0], 2'b00};

  always_comb begin
    w_pc_next = w_pc_plus4;
    if (i_exception) begin
      w_pc_next = EXC_VECTOR;
    end else if (i_stall) begin
      w_pc_next = r_pc;
    end else if (i_jr) begin
      w_pc_next = i_jr_target;
    end else if (i_jump) begin
      w_pc_next = w_jump_addr;
    end else if (i_branch_taken) begin
      w_pc_next = i_branch_target;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // jr outranks jump, so a push and a pop never coincide.
  assign w_push    = i_jump & i_link & ~i_jr & ~i_stall & ~i_exception;
  assign w_pop     = i_jr & i_jr_is_return & ~i_stall & ~i_exception;
  assign w_empty   = (r_count == '0);
  assign w_top_inc = r_top + PTR_W'(1);
  assign w_top_dec = r_top - PTR_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        r_ras[i] <= '0;
      end
      r_top       <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= w_pop & w_empty;
      if (i_exception) begin
        r_count <= '0;
      end else if (w_push) begin
        // When full this overwrites the oldest entry; count just saturates.
        r_ras[w_top_inc] <= w_pc_plus4;
        r_top            <= w_top_inc;
        if (r_count != CNT_MAX) begin
          r_count <= r_count + CNT_W'(1);
        end
      end else if (w_pop && !w_empty) begin
        r_top   <= w_top_dec;
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_pc             = r_pc;
  assign o_pc_plus4       = w_pc_plus4;
  assign o_ras_top        = r_ras[r_top];
  assign o_ras_empty      = w_empty;
  assign o_ras_mispredict = i_jr & i_jr_is_return & ~w_empty & (i_jr_target != o_ras_top);
  assign o_ras_underflow  = r_underflow;

endmodule
